// File: rtl/imem_boot_loader.sv
// Byte-serial boot loader: parses a length-prefixed, XOR-checksummed image,
// writes little-endian words into IMEM and releases the core once the image verifies.
module imem_boot_loader #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst_n,
    output logic        load_done,
    output logic        load_error
);

    localparam int IDX_W = $clog2(DEPTH_WORDS) + 1;

    typedef enum logic [2:0] {
        ST_LEN0  = 3'd0,
        ST_LEN1  = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHK   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    state_t           state_r;
    logic [7:0]       len_lo_r;
    logic [15:0]      len_r;
    logic [1:0]       byte_cnt_r;
    logic [IDX_W-1:0] word_idx_r;
    logic [23:0]      shift_r;
    logic [7:0]       xor_r;

    logic             ready_s;
    logic             accept_s;
    logic [15:0]      len_s;
    logic             len_over_s;
    logic             last_word_s;

    // Running image checksum: fold one byte into the accumulator.
    function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    // Byte address of a word slot; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [IDX_W-1:0] idx);
        return BASE_ADDR + (32'(idx) << 2);
    endfunction

    // Ready decode: the loader consumes bytes in every parsing state.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            ST_LEN0, ST_LEN1, ST_DATA, ST_CHK: ready_s = 1'b1;
            ST_DONE, ST_ERROR:                 ready_s = 1'b0;
            default:                           ready_s = 1'b0;
        endcase
    end

    assign rx_ready    = ready_s;
    assign accept_s    = rx_valid && ready_s;
    assign len_s       = {rx_data, len_lo_r};
    assign len_over_s  = ({1'b0, len_s} > 17'(DEPTH_WORDS));
    assign last_word_s = ((17'(word_idx_r) + 17'd1) == {1'b0, len_r});

    // Parser FSM with registered write port and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_LEN0;
            len_lo_r   <= 8'h00;
            len_r      <= 16'h0000;
            byte_cnt_r <= 2'd0;
            word_idx_r <= '0;
            shift_r    <= 24'h00_0000;
            xor_r      <= 8'h00;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= 32'h0000_0000;
            core_rst_n <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (accept_s) begin
                case (state_r)
                    ST_LEN0: begin
                        len_lo_r <= rx_data;
                        xor_r    <= xor_fold(xor_r, rx_data);
                        state_r  <= ST_LEN1;
                    end
                    ST_LEN1: begin
                        len_r <= len_s;
                        xor_r <= xor_fold(xor_r, rx_data);
                        if (len_over_s) begin
                            state_r    <= ST_ERROR;
                            load_error <= 1'b1;
                        end else if (len_s == 16'd0) begin
                            state_r <= ST_CHK;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        xor_r      <= xor_fold(xor_r, rx_data);
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        case (byte_cnt_r)
                            2'd0: shift_r[7:0]   <= rx_data;
                            2'd1: shift_r[15:8]  <= rx_data;
                            2'd2: shift_r[23:16] <= rx_data;
                            2'd3: begin
                                imem_we    <= 1'b1;
                                imem_wdata <= {rx_data, shift_r};
                                imem_addr  <= word_addr(word_idx_r);
                                word_idx_r <= word_idx_r + IDX_W'(1);
                                if (last_word_s) begin
                                    state_r <= ST_CHK;
                                end
                            end
                            default: shift_r <= shift_r;
                        endcase
                    end
                    ST_CHK: begin
                        if (rx_data == xor_r) begin
                            state_r    <= ST_DONE;
                            load_done  <= 1'b1;
                            core_rst_n <= 1'b1;
                        end else begin
                            state_r    <= ST_ERROR;
                            load_error <= 1'b1;
                        end
                    end
                    default: state_r <= state_r;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader against an image-level reference model.
module tb_imem_boot_loader;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        load_done;
    logic        load_error;

    int n_checks = 0;
    int n_errors = 0;
    int we_total = 0;

    imem_boot_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_rst_n(core_rst_n),
        .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) we_total++;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk_eq({tag, "_rx_ready"},   32'(rx_ready),   32'd1);
        chk_eq({tag, "_imem_we"},    32'(imem_we),    32'd0);
        chk_eq({tag, "_imem_addr"},  imem_addr,       BASE);
        chk_eq({tag, "_imem_wdata"}, imem_wdata,      32'd0);
        chk_eq({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
        chk_eq({tag, "_load_done"},  32'(load_done),  32'd0);
        chk_eq({tag, "_load_error"}, 32'(load_error), 32'd0);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Offer one byte after a gap; returns once it has been accepted (or timed out).
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        int waits;
        waits = 0;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!rx_ready) begin
            chk_eq("rx_ready_timeout", 32'(rx_ready), 32'd1);
            rx_valid = 1'b0;
            ok = 1'b0;
        end else begin
            @(negedge clk);
            rx_valid = 1'b0;
            ok = 1'b1;
        end
    endtask

    function automatic byte_q_t make_image(input int n, input bit corrupt);
        byte_q_t q;
        logic [7:0]  x;
        logic [31:0] wd;
        q.push_back(8'(n));
        q.push_back(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            wd = $urandom;
            for (int k = 0; k < 4; k++) q.push_back(wd[8*k +: 8]);
        end
        x = 8'h00;
        foreach (q[i]) x = x ^ q[i];
        if (corrupt) x = x ^ 8'($urandom_range(1, 255));
        q.push_back(x);
        return q;
    endfunction

    // Stream an image and check every write and the final status against the image rules.
    task automatic run_image(input byte_q_t img, input int max_gap);
        int n;
        bit over;
        int base;
        int w;
        bit ok;
        bit good;
        logic [7:0] acc;
        n    = int'(img[0]) + 256 * int'(img[1]);
        over = (n > DEPTH);
        base = we_total;
        acc  = 8'h00;
        for (int j = 0; j < img.size(); j++) begin
            send_byte(img[j], int'($urandom_range(0, max_gap)), ok);
            if (!ok) break;
            if (j == 1 && over) begin
                chk_eq("len_error",        32'(load_error), 32'd1);
                chk_eq("len_error_ready",  32'(rx_ready),   32'd0);
                chk_eq("len_error_core",   32'(core_rst_n), 32'd0);
                chk_eq("len_error_done",   32'(load_done),  32'd0);
                break;
            end
            if (j >= 2 && j < 2 + 4*n && ((j - 2) % 4) == 3) begin
                w = (j - 2) / 4;
                chk_eq("write_we",   32'(imem_we), 32'd1);
                chk_eq("write_addr", imem_addr,    BASE + 32'(4 * w));
                chk_eq("write_data", imem_wdata,   {img[j], img[j-1], img[j-2], img[j-3]});
            end else begin
                chk_eq("no_write", 32'(imem_we), 32'd0);
            end
            if (j == 2 + 4*n) begin
                good = (img[j] == acc);
                chk_eq("final_done",  32'(load_done),  32'(good));
                chk_eq("final_error", 32'(load_error), 32'(!good));
                chk_eq("final_core",  32'(core_rst_n), 32'(good));
            end else begin
                chk_eq("core_held", 32'(core_rst_n), 32'd0);
            end
            acc = acc ^ img[j];
        end
        repeat (3) @(negedge clk);
        chk_eq("idle_ready",  32'(rx_ready),         32'd0);
        chk_eq("write_count", 32'(we_total - base),  over ? 32'd0 : 32'(n));
    endtask

    initial begin
        byte_q_t img;
        bit ok;
        int base;

        do_reset();
        img = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC2};
        run_image(img, 0);

        do_reset();
        img = '{8'h00, 8'h00, 8'h00};
        run_image(img, 0);

        do_reset();
        img = '{8'h01, 8'h01};
        run_image(img, 0);

        do_reset();
        img = '{8'hFF, 8'hFF};
        run_image(img, 2);

        do_reset();
        img = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
        run_image(img, 0);

        do_reset();
        run_image(make_image(2, 1'b0), 5);

        // Reset after three data bytes, then a clean reload.
        do_reset();
        base = we_total;
        img = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50};
        foreach (img[i]) send_byte(img[i], 0, ok);
        rst_n = 1'b0;
        #1;
        chk_reset_values("midload");
        chk_eq("midload_no_write", 32'(we_total - base), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        img = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC2};
        run_image(img, 1);

        do_reset();
        run_image(make_image(DEPTH, 1'b0), 0);

        do_reset();
        img = make_image(DEPTH, 1'b0);
        img[0] = 8'h01;
        img[1] = 8'h01;
        run_image(img, 0);

        for (int t = 0; t < 10; t++) begin
            do_reset();
            run_image(make_image(int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0)),
                      int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Byte-serial boot loader that sits directly upstream of the core's instruction memory and PC. It receives a length-prefixed, checksummed program image over a valid/ready byte stream, assembles little-endian 32-bit words and writes them into IMEM through a dedicated write port. It holds the core in reset until a verified image is in place, then releases it so the PC starts fetching from `BASE_ADDR`.

## Interface
- `DEPTH_WORDS`, default 256: IMEM capacity in 32-bit words; maximum accepted word count.
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first loaded word.
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `rx_valid` input, 1 bit: `rx_data` holds a byte.
- `rx_data` input, 8 bits: incoming image byte.
- `rx_ready` output, 1 bit: loader can accept a byte this cycle.
- `imem_we` output, 1 bit: one-cycle IMEM write strobe.
- `imem_addr` output, 32 bits: byte address of the write, word-aligned.
- `imem_wdata` output, 32 bits: assembled instruction word.
- `core_rst_n` output, 1 bit: active-low reset to PC/register file; 0 until load succeeds.
- `load_done` output, 1 bit: image loaded and verified (sticky).
- `load_error` output, 1 bit: length or checksum error (sticky).

## Operation
- Image format: LEN_LO, LEN_HI (16-bit word count N), then 4·N data bytes (least significant byte first), then one CHK byte.
- CHK = XOR of every preceding byte in the image (length and data bytes).
- A byte is accepted on a rising edge with `rx_valid && rx_ready`; no other edge changes parsing state.
- FSM states: LEN0 -> LEN1 -> DATA -> CHK -> DONE, with ERROR reachable from LEN1 and CHK.
- LEN0: latch low count byte and go to LEN1.
- LEN1: form N. If N > DEPTH_WORDS go to ERROR. If N == 0 go to CHK. Otherwise go to DATA.
- DATA: 2-bit byte counter places byte k at bits [8k+7:8k] of the word shift register. On byte 3, issue the write and advance the word index. After word N−1, go to CHK.
- CHK: if received byte equals the running XOR, go to DONE, else go to ERROR.
- DONE: `load_done`=1, `core_rst_n`=1, `rx_ready`=0. Holds until `rst_n`.
- ERROR: `load_error`=1, `core_rst_n`=0, `rx_ready`=0. Holds until `rst_n`.
- Word index is log2(DEPTH_WORDS)+1 bits wide. `imem_addr` = BASE_ADDR + 4·index, wrapping modulo 2^32.
- Running XOR is 8 bits and is cleared on reset.

## Timing
- Reset values: state=LEN0, `rx_ready`=1, `imem_we`=0, `imem_addr`=BASE_ADDR, `imem_wdata`=0, `core_rst_n`=0, `load_done`=0, `load_error`=0. Internal counters and XOR are all 0.
- `rx_ready` is combinational from state: 1 in LEN0, LEN1, DATA and CHK.
- Write latency: `imem_we`, `imem_addr` and `imem_wdata` are registered. They are valid for exactly one cycle, the cycle after the 4th byte of a word is accepted.
- Back-to-back bytes are allowed every cycle. Gaps in `rx_valid` of any length are tolerated with no timeout.
- The last IMEM write always completes before the CHK byte can be accepted.
- `core_rst_n` and `load_done` rise on the edge that accepts a matching CHK byte.
- `load_error` rises on the edge that accepts the offending LEN_HI or CHK byte.
- Reset mid-load (`rst_n` low at any time) returns all outputs to reset values immediately.
  - A write strobe in flight is dropped.
  - Words already written to IMEM are not erased.
  - The next byte after reset is treated as LEN_LO.
- N == DEPTH_WORDS is legal; the final address is BASE_ADDR + 4·(DEPTH_WORDS−1).

## Test plan
- One-word image: bytes 01 00 93 00 50 00 C2 -> single `imem_we` pulse with addr 0x00000000, data 0x00500093, one cycle after byte 0x00 (the 6th byte). Then `core_rst_n`=1 and `load_done`=1.
- Empty image: bytes 00 00 00 -> no `imem_we`; `load_done`=1 after 3rd byte; `rx_ready`=0 thereafter.
- Over-length (DEPTH_WORDS=256): bytes 01 01 -> `load_error`=1 after 2nd byte. `rx_ready`=0, `core_rst_n` stays 0, and no writes occur.
- Bad checksum: one-word image with CHK=C3 -> word still written to addr 0. `load_error`=1, `load_done`=0, `core_rst_n`=0.
- Backpressure/gaps: two-word image with random 0–5 cycle `rx_valid` gaps -> writes go to addr 0x0 then 0x4 with correct data, followed by DONE.
- Reset mid-load: assert `rst_n`=0 after 3 data bytes, then resend a full valid one-word image -> exactly one write, to addr 0, followed by DONE.
